pipe_trace_gen: RTL and testbench
=================================

PIPE_TRACE_GEN -- requirements
Module: pipe_trace_gen

Interface
REQ-001 Parameter ID_W, default 8, is the instruction tag width; tags wrap modulo 2^ID_W.
REQ-002 Parameter RQ_DEPTH, default 4, is the retire-queue depth (power of two, at least 2).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  IF/ID hold (load-use or similar): fetch and decode freeze.
REQ-006 flush  in  1  taken branch resolved in decode: the instruction now in fetch is squashed.
REQ-007 hlt_dec  in  1  the instruction in decode is HLT.
REQ-008 f_vld/d_vld/x_vld/m_vld/w_vld  out  1 each  the stage holds a real instruction.
REQ-009 f_id/d_id/x_id/m_id/w_id  out  ID_W each  tag of the instruction in that stage.
REQ-010 ret_valid  out  1  a retire record is available.
REQ-011 ret_ready  in  1  the consumer accepts the record.
REQ-012 ret_id  out  ID_W  tag of the head retire record.
REQ-013 ret_halt  out  1  the head record is the HLT instruction.
REQ-014 done  out  1  HLT has retired; the trace is complete.
REQ-015 rq_ovf  out  1  sticky flag: a retire record was dropped.

Function
REQ-016 Tag generator: next_tag increments on every cycle where fetch advances (state RUN and !stall); f_id = next_tag.
REQ-017 Normal advance (!stall): D<=F, X<=D, M<=X, W<=M (valid, id and halt bit all move together).
REQ-018 stall=1: F and D hold; X loads a bubble (valid 0); M<=X; W<=M.
REQ-019 flush=1 with stall=0: D loads a bubble instead of F.
REQ-020 flush with stall: stall wins; the flush has no effect that cycle.
REQ-021 FSM states: RUN, DRAIN, DONE.
REQ-022 RUN: f_vld=1.
REQ-023 RUN to DRAIN on hlt_dec & d_vld & !stall; the halt bit is attached to that instruction as it enters X.
REQ-024 DRAIN: f_vld=0, next_tag frozen, D loads bubbles.
REQ-025 DRAIN to DONE when w_vld & the W-stage halt bit are set; done=1 from the following cycle.
REQ-026 DONE is terminal until reset; all stage valids are 0.
REQ-027 Retire push: every cycle w_vld=1 pushes {w_id, halt bit} into the retire queue.
REQ-028 Handshake: a record pops when ret_valid & ret_ready; ret_valid = queue not empty; head fields stay stable while ret_valid & !ret_ready.
REQ-029 Push and pop in the same cycle are both honoured, including when the queue is full (occupancy unchanged).
REQ-030 Push when full with no pop: the record is dropped and rq_ovf is set (sticky until reset).
REQ-031 Latency: an instruction fetched at cycle n with no stall or flush appears at ret_valid in cycle n+5.
REQ-032 Tag wrap: 2^ID_W-1 is followed by 0 with no gap.

Reset
REQ-033 Reset values:
- state = RUN; next_tag = 0.
- all stage valids, ids and halt bits = 0.
- queue empty, so ret_valid = 0.
- done = 0; rq_ovf = 0.
REQ-034 Reset asserted mid-operation discards all in-flight stages and queued records immediately, regardless of the clock.
REQ-035 The first cycle after reset deassertion shows f_vld=1, f_id=0.

Configuration
REQ-036 Macro TRACE_CYCLE_STAMP_EN:
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) is stored with each retire record and presented on output ret_cycle [31:0], equal to the counter value in the push cycle.
- Undefined: the counter and the ret_cycle port are absent; all other behaviour is identical.

Structure
REQ-037 Shared package pipe_trace_pkg holds:
- trace_state_t enum (RUN, DRAIN, DONE).
- stage_tag_t struct (vld, id, halt).
- ret_rec_t struct.
- Constant NUM_STAGES = 5.
REQ-038 The retire queue is the sub-module trace_ret_fifo, parameterised by RQ_DEPTH and record type, with push, pop, full, empty and an overflow pulse.

Verification
REQ-039 Reset, then 10 free-running cycles with ret_ready=1: records carry ids 0,1,2,... one per cycle; the first record appears in cycle 5.
REQ-040 stall high for 2 cycles while id 3 is in D: ids 3 and 4 hold, two bubbles flow to W, retire order stays 0..N with no duplicates or gaps.
REQ-041 flush pulse while id 6 is in F: id 6 never retires; the next retired id is 7.
REQ-042 hlt_dec while id 9 is in D: the last retired record is id 9 with ret_halt=1, done rises the next cycle, f_vld stays 0.
REQ-043 ret_ready=0 for 6 cycles: the queue fills at 4 records, the 5th push sets rq_ovf, and the held head keeps id and halt stable.
REQ-044 ID_W=3 run for 12 fetches: ids wrap 7 to 0; reset asserted mid-run clears ret_valid and all stage valids without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared types and constants for the pipeline trace generator.
//   trace_state_t : top-level trace FSM states (RUN, DRAIN, DONE)
//   stage_tag_t   : per-stage contents (valid, tag, halt bit)
//   ret_rec_t     : retire-queue record (tag, halt bit, optional cycle stamp)
// Tags are carried at TAG_W_MAX bits; the top uses only its low ID_W bits.
// Macro TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp to ret_rec_t.
package pipe_trace_pkg;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned TAG_W_MAX  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic                 vld;
    logic [TAG_W_MAX-1:0] id;
    logic                 halt;
  } stage_tag_t;

  typedef struct packed {
    logic [TAG_W_MAX-1:0] id;
    logic                 halt;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]          cycle;
`endif
  } ret_rec_t;

  localparam stage_tag_t BUBBLE = '0;

endpackage

// File: rtl/trace_ret_fifo.sv
// Retire queue: synchronous FIFO of generic records.
//   clk, rst   : clock, asynchronous active-high reset (queue becomes empty)
//   push       : write push_rec this cycle (dropped if full and not popping)
//   push_rec   : record to write
//   pop        : consume head (ignored when empty)
//   head       : current head record (stable until popped)
//   full/empty : occupancy flags
//   ovf        : one-cycle pulse when a push was dropped
// DEPTH must be a power of two, at least 2.
module trace_ret_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         rec_t = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_rec,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty,
  output logic ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;
  logic          do_push;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push into a full queue still lands.
    do_push = push & (~full | do_pop);
    ovf     = push & full & ~do_pop;
    head    = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pipe_trace_gen.sv
// Five-stage (F/D/X/M/W) pipeline occupancy trace generator.
// Tags instructions at fetch, moves them through the stages honouring
// stall/flush, drains on HLT and queues one retire record per W-stage
// instruction for a ready/valid consumer.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : freeze F and D, inject a bubble into X
//   flush           : squash the instruction in F (ignored under stall)
//   hlt_dec         : instruction in D is HLT
//   {f,d,x,m,w}_vld : stage holds a real instruction
//   {f,d,x,m,w}_id  : tag of the instruction in that stage
//   ret_valid/ready : retire record handshake
//   ret_id/ret_halt : head record fields
//   ret_cycle       : head record cycle stamp (only with TRACE_CYCLE_STAMP_EN)
//   done            : HLT has retired
//   rq_ovf          : sticky, a retire record was dropped
module pipe_trace_gen
  import pipe_trace_pkg::*;
#(
  parameter int unsigned ID_W     = 8,
  parameter int unsigned RQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            hlt_dec,
  output logic            f_vld,
  output logic            d_vld,
  output logic            x_vld,
  output logic            m_vld,
  output logic            w_vld,
  output logic [ID_W-1:0] f_id,
  output logic [ID_W-1:0] d_id,
  output logic [ID_W-1:0] x_id,
  output logic [ID_W-1:0] m_id,
  output logic [ID_W-1:0] w_id,
  output logic            ret_valid,
  input  logic            ret_ready,
  output logic [ID_W-1:0] ret_id,
  output logic            ret_halt,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [31:0]     ret_cycle,
`endif
  output logic            done,
  output logic            rq_ovf
);

  localparam int unsigned S_D = 1;
  localparam int unsigned S_X = 2;
  localparam int unsigned S_M = 3;
  localparam int unsigned S_W = 4;

  trace_state_t    state_q;
  trace_state_t    state_d;
  logic [ID_W-1:0] next_tag_q;
  stage_tag_t      stg_q [1:NUM_STAGES-1];
  stage_tag_t      f_stage;
  logic            run;
  logic            fetch_adv;
  logic            halt_adv;
  logic            d_kill;
  logic            rq_ovf_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_ovf;
  logic            pop;
  ret_rec_t        push_rec;
  ret_rec_t        head;

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]     cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 32'd1;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_adv) state_d = DRAIN;
      DRAIN:   if (stg_q[S_W].vld & stg_q[S_W].halt) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    run       = (state_q == RUN);
    fetch_adv = run & ~stall;
    halt_adv  = run & hlt_dec & stg_q[S_D].vld & ~stall;
    // The fetch slot behind an advancing HLT is squashed so HLT retires last.
    d_kill    = ~run | flush | halt_adv;
    // Reset is asynchronous, so F (derived from state) is masked while it is held.
    f_vld     = run & ~rst;
    done      = (state_q == DONE);
  end

  always_comb begin
    f_stage      = BUBBLE;
    f_stage.vld  = run;
    f_stage.id   = TAG_W_MAX'(next_tag_q);
    f_stage.halt = 1'b0;
  end

  // Tag generator and stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_tag_q <= '0;
      for (int unsigned i = 1; i < NUM_STAGES; i++) stg_q[i] <= BUBBLE;
    end else begin
      if (fetch_adv) next_tag_q <= next_tag_q + ID_W'(1);
      if (!stall) begin
        stg_q[S_D] <= d_kill ? BUBBLE : f_stage;
        stg_q[S_X] <= '{vld: stg_q[S_D].vld, id: stg_q[S_D].id, halt: halt_adv};
      end else begin
        stg_q[S_X] <= BUBBLE;
      end
      stg_q[S_M] <= stg_q[S_X];
      stg_q[S_W] <= stg_q[S_M];
    end
  end

  // Retire queue
  always_comb begin
    push_rec      = '0;
    push_rec.id   = stg_q[S_W].id;
    push_rec.halt = stg_q[S_W].halt;
`ifdef TRACE_CYCLE_STAMP_EN
    push_rec.cycle = cyc_q;
`endif
  end

  assign pop = ~fifo_empty & ret_ready;

  trace_ret_fifo #(
    .DEPTH (RQ_DEPTH),
    .rec_t (ret_rec_t)
  ) u_ret_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (stg_q[S_W].vld),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (fifo_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rq_ovf_q <= 1'b0;
    else if (fifo_ovf) rq_ovf_q <= 1'b1;
  end

  // Outputs
  always_comb begin
    f_id      = next_tag_q;
    d_vld     = stg_q[S_D].vld;
    x_vld     = stg_q[S_X].vld;
    m_vld     = stg_q[S_M].vld;
    w_vld     = stg_q[S_W].vld;
    d_id      = stg_q[S_D].id[ID_W-1:0];
    x_id      = stg_q[S_X].id[ID_W-1:0];
    m_id      = stg_q[S_M].id[ID_W-1:0];
    w_id      = stg_q[S_W].id[ID_W-1:0];
    ret_valid = ~fifo_empty;
    ret_id    = head.id[ID_W-1:0];
    ret_halt  = head.halt;
    rq_ovf    = rq_ovf_q;
  end

`ifdef TRACE_CYCLE_STAMP_EN
  assign ret_cycle = head.cycle;
`endif

  if (ID_W < TAG_W_MAX) begin : g_tag_hi
    logic unused_tag_hi;
    assign unused_tag_hi = |{head.id[TAG_W_MAX-1:ID_W], fifo_full};
  end else begin : g_tag_full
    logic unused_full;
    assign unused_full = fifo_full;
  end

endmodule

// File: tb/tb_pipe_trace_gen.sv
module tb_pipe_trace_gen;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (ID_W = 8)
  logic       rst, stall, flush, hlt_dec, ret_ready;
  logic       f_vld, d_vld, x_vld, m_vld, w_vld;
  logic [7:0] f_id, d_id, x_id, m_id, w_id, ret_id;
  logic       ret_valid, ret_halt, done, rq_ovf;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] ret_cycle, ret_cycle3;
`endif

  // Narrow-tag DUT (ID_W = 3)
  logic       rst3, stall3, flush3, hlt_dec3, ret_ready3;
  logic       f_vld3, d_vld3, x_vld3, m_vld3, w_vld3;
  logic [2:0] f_id3, d_id3, x_id3, m_id3, w_id3, ret_id3;
  logic       ret_valid3, ret_halt3, done3, rq_ovf3;

  pipe_trace_gen #(.ID_W(8), .RQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .hlt_dec(hlt_dec),
    .f_vld(f_vld), .d_vld(d_vld), .x_vld(x_vld), .m_vld(m_vld), .w_vld(w_vld),
    .f_id(f_id), .d_id(d_id), .x_id(x_id), .m_id(m_id), .w_id(w_id),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_id(ret_id), .ret_halt(ret_halt),
`ifdef TRACE_CYCLE_STAMP_EN
    .ret_cycle(ret_cycle),
`endif
    .done(done), .rq_ovf(rq_ovf)
  );

  pipe_trace_gen #(.ID_W(3), .RQ_DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst3), .stall(stall3), .flush(flush3), .hlt_dec(hlt_dec3),
    .f_vld(f_vld3), .d_vld(d_vld3), .x_vld(x_vld3), .m_vld(m_vld3), .w_vld(w_vld3),
    .f_id(f_id3), .d_id(d_id3), .x_id(x_id3), .m_id(m_id3), .w_id(w_id3),
    .ret_valid(ret_valid3), .ret_ready(ret_ready3), .ret_id(ret_id3), .ret_halt(ret_halt3),
`ifdef TRACE_CYCLE_STAMP_EN
    .ret_cycle(ret_cycle3),
`endif
    .done(done3), .rq_ovf(rq_ovf3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: instructions as (valid, tag, halt) tuples per stage,
  // retire queue as a bounded SV queue.
  typedef struct { bit v; int id; bit h; } slot_t;
  typedef struct { int id; bit h; } exp_rec_t;

  slot_t    pipe [1:4];            // D, X, M, W
  int       m_state;               // 0 running, 1 draining, 2 finished
  int       m_tag;
  bit       m_ovf;
  exp_rec_t m_q [$];

  task automatic model_reset();
    m_state = 0;
    m_tag   = 0;
    m_ovf   = 1'b0;
    m_q.delete();
    for (int i = 1; i <= 4; i++) pipe[i] = '{1'b0, 0, 1'b0};
  endtask

  task automatic model_step(input bit st, input bit fl, input bit hl, input bit rd);
    bit    running, hadv, was_full, popd;
    slot_t w;
    running  = (m_state == 0);
    hadv     = running && hl && pipe[1].v && !st;
    was_full = (m_q.size() == DEPTH);
    popd     = (m_q.size() > 0) && rd;
    w        = pipe[4];
    if (popd) m_q.delete(0);
    if (w.v) begin
      if (was_full && !popd) m_ovf = 1'b1;
      else m_q.push_back('{w.id, w.h});
    end
    if (m_state == 1 && w.v && w.h) m_state = 2;
    else if (hadv) m_state = 1;
    pipe[4] = pipe[3];
    pipe[3] = pipe[2];
    if (st) begin
      pipe[2] = '{1'b0, 0, 1'b0};
    end else begin
      pipe[2]   = pipe[1];
      pipe[2].h = hadv;
      if (fl || !running || hadv) pipe[1] = '{1'b0, 0, 1'b0};
      else pipe[1] = '{1'b1, m_tag, 1'b0};
      if (running) m_tag = (m_tag + 1) % 256;
    end
  endtask

  task automatic compare_all();
    check("f_vld", 64'(f_vld), 64'((m_state == 0) && !rst));
    check("f_id", 64'(f_id), 64'(m_tag));
    check("d_vld", 64'(d_vld), 64'(pipe[1].v));
    check("x_vld", 64'(x_vld), 64'(pipe[2].v));
    check("m_vld", 64'(m_vld), 64'(pipe[3].v));
    check("w_vld", 64'(w_vld), 64'(pipe[4].v));
    if (pipe[1].v) check("d_id", 64'(d_id), 64'(pipe[1].id));
    if (pipe[2].v) check("x_id", 64'(x_id), 64'(pipe[2].id));
    if (pipe[3].v) check("m_id", 64'(m_id), 64'(pipe[3].id));
    if (pipe[4].v) check("w_id", 64'(w_id), 64'(pipe[4].id));
    check("ret_valid", 64'(ret_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("ret_id", 64'(ret_id), 64'(m_q[0].id));
      check("ret_halt", 64'(ret_halt), 64'(m_q[0].h));
    end
    check("done", 64'(done), 64'(m_state == 2));
    check("rq_ovf", 64'(rq_ovf), 64'(m_ovf));
  endtask

  task automatic cycle(input bit st, input bit fl, input bit hl, input bit rd);
    stall = st; flush = fl; hlt_dec = hl; ret_ready = rd;
    model_step(st, fl, hl, rd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; hlt_dec = 1'b0; ret_ready = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first;
    int last_id;
    bit last_h;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; hlt_dec = 1'b0; ret_ready = 1'b1;
    rst3 = 1'b1; stall3 = 1'b0; flush3 = 1'b0; hlt_dec3 = 1'b0; ret_ready3 = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Free run: first record appears in cycle 5, one per cycle afterwards
    do_reset();
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (ret_valid) first = i;
    end
    check("first_ret_cycle", 64'(first), 64'd5);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Two-cycle stall while id 3 is in D
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_stall_d_id", 64'(d_id), 64'd3);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("stall_hold_d_id", 64'(d_id), 64'd3);
    check("stall_hold_f_id", 64'(f_id), 64'd4);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush while id 6 is in F
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_flush_f_id", 64'(f_id), 64'd6);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_d_bubble", 64'(d_vld), 64'd0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // HLT while id 9 is in D
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_hlt_d_id", 64'(d_id), 64'd9);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    last_id = -1; last_h = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (ret_valid) begin last_id = int'(ret_id); last_h = ret_halt; end
    end
    check("hlt_done", 64'(done), 64'd1);
    check("hlt_last_id", 64'(last_id), 64'd9);
    check("hlt_last_halt", 64'(last_h), 64'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("hlt_f_vld", 64'(f_vld), 64'd0);

    // Back-pressure: queue fills at 4, 5th push overflows, head held
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_ovf", 64'(rq_ovf), 64'd1);
    check("bp_head_id", 64'(ret_id), 64'd0);
    check("bp_head_halt", 64'(ret_halt), 64'd0);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_state == 2 || (i % 150) == 149) do_reset();
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0);
    end

    // Narrow tags: wrap 7 -> 0, then asynchronous reset mid-cycle
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("w3_f_id_start", 64'(f_id3), 64'd0);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      check("w3_f_id", 64'(f_id3), 64'(i % 8));
      if (i >= 5) begin
        check("w3_ret_valid", 64'(ret_valid3), 64'd1);
        check("w3_ret_id", 64'(ret_id3), 64'((i - 5) % 8));
      end
    end
    #2;
    rst3 = 1'b1;
    #1;
    check("w3_async_ret_valid", 64'(ret_valid3), 64'd0);
    check("w3_async_vlds", 64'({f_vld3, d_vld3, x_vld3, m_vld3, w_vld3}), 64'd0);
    check("w3_async_f_id", 64'(f_id3), 64'd0);
    @(negedge clk);
    rst3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
